// File: rtl/matrix_pkg.sv
// matrix_pkg: shared FSM state, default matrix geometry and
// width helpers for the result write path.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WAIT_DONE,
    DONE
  } arb_state_t;

  localparam int DEF_LANES  = 4;
  localparam int DEF_ELEM   = 8;
  localparam int DEF_SIZE_A = 32;
  localparam int DEF_SIZE_B = 32;

  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  // counter must hold the full cell count, not just the last address
  function automatic int cnt_width(input int cells);
    return $clog2(cells) + 1;
  endfunction

  localparam int DEF_ROW_W  = clog2_min1(DEF_SIZE_A);
  localparam int DEF_COL_W  = clog2_min1(DEF_SIZE_B);
  localparam int DEF_ADDR_W = clog2_min1(DEF_SIZE_A * DEF_SIZE_B);

endpackage

// File: rtl/result_write_arbiter_if.sv
// result_write_arbiter_if: lane handshake bundle plus the
// matrix compiler write port.
interface result_write_arbiter_if
  import matrix_pkg::*;
#(
  parameter int NUM_LANES        = DEF_LANES,
  parameter int MAX_ELEMENT_SIZE = DEF_ELEM,
  parameter int ROW_W            = DEF_ROW_W,
  parameter int COL_W            = DEF_COL_W
);
  logic [NUM_LANES-1:0]                  lane_valid;
  logic [NUM_LANES-1:0]                  lane_ready;
  logic [NUM_LANES*ROW_W-1:0]            lane_row;
  logic [NUM_LANES*COL_W-1:0]            lane_col;
  logic [NUM_LANES*MAX_ELEMENT_SIZE-1:0] lane_data;

  logic                        out_valid;
  logic [ROW_W-1:0]            out_row;
  logic [COL_W-1:0]            out_col;
  logic [MAX_ELEMENT_SIZE-1:0] out_element;

  modport master (
    output lane_valid,
    output lane_row,
    output lane_col,
    output lane_data,
    input  lane_ready,
    input  out_valid,
    input  out_row,
    input  out_col,
    input  out_element
  );

  modport slave (
    input  lane_valid,
    input  lane_row,
    input  lane_col,
    input  lane_data,
    output lane_ready,
    output out_valid,
    output out_row,
    output out_col,
    output out_element
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; priority starts at the
// lane following the most recently granted one.
module rr_arbiter
  import matrix_pkg::*;
#(
  parameter int NUM_LANES = DEF_LANES
) (
  input  logic                 inter_refclk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] req,
  input  logic                 advance,
  output logic [NUM_LANES-1:0] grant
);
  localparam int PW = clog2_min1(NUM_LANES);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant   = '0;
    gnt_idx = ptr;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_LANES);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  always_ff @(posedge inter_refclk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= PW'((int'(gnt_idx) + 1) % NUM_LANES);
    end
  end

endmodule

// File: rtl/result_write_arbiter.sv
// result_write_arbiter: collects lane results round-robin and
// forwards first-time, in-range writes to the matrix compiler.
module result_write_arbiter
  import matrix_pkg::*;
#(
  parameter int NUM_LANES        = DEF_LANES,
  parameter int MAX_ELEMENT_SIZE = DEF_ELEM,
  parameter int MAX_SIZE_A       = DEF_SIZE_A,
  parameter int MAX_SIZE_B       = DEF_SIZE_B
) (
  input  logic inter_refclk,
  input  logic rst,
  input  logic start,
  input  logic compile_done,
  result_write_arbiter_if.slave bus,
  output logic busy,
  output logic frame_done,
  output logic dup_error
);
  localparam int ROW_W  = clog2_min1(MAX_SIZE_A);
  localparam int COL_W  = clog2_min1(MAX_SIZE_B);
  localparam int CELLS  = MAX_SIZE_A * MAX_SIZE_B;
  localparam int ADDR_W = clog2_min1(CELLS);
  localparam int CNT_W  = cnt_width(CELLS);
  localparam int EW     = MAX_ELEMENT_SIZE;

  arb_state_t state;
  arb_state_t state_nxt;

  logic [NUM_LANES-1:0] req;
  logic [NUM_LANES-1:0] grant;
  logic                 collect_en;
  logic                 clear_frame;

  logic [ROW_W-1:0]  sel_row;
  logic [COL_W-1:0]  sel_col;
  logic [EW-1:0]     sel_data;
  logic [ADDR_W-1:0] addr;
  logic [CELLS-1:0]  written;
  logic [CNT_W-1:0]  cnt;

  logic xfer;
  logic in_range;
  logic dup;
  logic accept;
  logic last;

  assign req = collect_en ? bus.lane_valid : '0;

  rr_arbiter #(
    .NUM_LANES (NUM_LANES)
  ) u_rr (
    .inter_refclk (inter_refclk),
    .rst          (rst),
    .req          (req),
    .advance      (xfer),
    .grant        (grant)
  );

  assign bus.lane_ready = grant;
  assign xfer           = |grant;

  always_comb begin
    sel_row  = '0;
    sel_col  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (grant[i]) begin
        sel_row  = bus.lane_row[i*ROW_W +: ROW_W];
        sel_col  = bus.lane_col[i*COL_W +: COL_W];
        sel_data = bus.lane_data[i*EW +: EW];
      end
    end
  end

  assign in_range = (int'(sel_row) < MAX_SIZE_A)
                 && (int'(sel_col) < MAX_SIZE_B);
  assign addr = ADDR_W'(int'(sel_row) * MAX_SIZE_B
                      + int'(sel_col));
  // out-of-range coordinates are dropped exactly like repeats
  assign dup    = !in_range || written[addr];
  assign accept = xfer && !dup;
  assign last   = accept && (cnt == CNT_W'(CELLS - 1));

  always_ff @(posedge inter_refclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start) state_nxt = COLLECT;
      COLLECT:   if (last) state_nxt = WAIT_DONE;
      WAIT_DONE: if (compile_done) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    collect_en  = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    clear_frame = 1'b0;
    unique case (state)
      IDLE:      clear_frame = start;
      COLLECT: begin
        collect_en = 1'b1;
        busy       = 1'b1;
      end
      WAIT_DONE: busy = 1'b1;
      DONE:      frame_done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge inter_refclk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_row     <= '0;
      bus.out_col     <= '0;
      bus.out_element <= '0;
      written         <= '0;
      cnt             <= '0;
      dup_error       <= 1'b0;
    end else begin
      bus.out_valid <= accept;
      if (accept) begin
        bus.out_row     <= sel_row;
        bus.out_col     <= sel_col;
        bus.out_element <= sel_data;
        written[addr]   <= 1'b1;
        cnt             <= cnt + CNT_W'(1);
      end
      if (xfer && dup) begin
        dup_error <= 1'b1;
      end
      if (clear_frame) begin
        written   <= '0;
        cnt       <= '0;
        dup_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_write_arbiter.sv
// tb_result_write_arbiter: randomized and directed frames checked
// against a queue-based reference model through a scoreboard.
module tb_result_write_arbiter;
  localparam int L  = 4;
  localparam int E  = 8;
  localparam int A  = 2;
  localparam int B  = 2;
  localparam int RW = 1;
  localparam int CW = 1;
  localparam int CELLS = A * B;

  localparam int P_IDLE = 0;
  localparam int P_COL  = 1;
  localparam int P_WAIT = 2;
  localparam int P_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic compile_done = 1'b0;
  logic busy;
  logic frame_done;
  logic dup_error;

  result_write_arbiter_if #(
    .NUM_LANES(L), .MAX_ELEMENT_SIZE(E),
    .ROW_W(RW), .COL_W(CW)
  ) bus ();

  result_write_arbiter #(
    .NUM_LANES(L), .MAX_ELEMENT_SIZE(E),
    .MAX_SIZE_A(A), .MAX_SIZE_B(B)
  ) dut (
    .inter_refclk (clk),
    .rst          (rst),
    .start        (start),
    .compile_done (compile_done),
    .bus          (bus),
    .busy         (busy),
    .frame_done   (frame_done),
    .dup_error    (dup_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         r;
    int         c;
    logic [7:0] d;
  } item_t;

  item_t lq[L][$];
  item_t expq[$];
  int    glog[$];

  int checks = 0;
  int errors = 0;

  int         m_phase = P_IDLE;
  int         m_prio  = 0;
  int         m_cnt   = 0;
  bit         m_written[CELLS];
  bit         m_dup = 1'b0;
  bit         m_ov  = 1'b0;
  logic [L-1:0] m_gnt = '0;
  logic [L-1:0] en_mask = '1;
  bit         rand_mode = 1'b0;
  int         outs = 0;
  int         xfers = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic item_t mk(int r, int c, int d);
    item_t it;
    it.r = r;
    it.c = c;
    it.d = 8'(d);
    return it;
  endfunction

  // priority scan starting at m_prio over the driven valids
  function automatic logic [L-1:0] exp_grant();
    logic [L-1:0] g;
    g = '0;
    if (m_phase != P_COL) return g;
    for (int k = 0; k < L; k++) begin
      int l;
      l = (m_prio + k) % L;
      if (bus.lane_valid[l]) begin
        g[l] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // reference model: advances once per clock edge
  always @(posedge clk) begin
    logic [L-1:0] g;
    g = exp_grant();
    m_ov  = 1'b0;
    m_gnt = '0;
    if (rst) begin
      m_phase = P_IDLE;
      m_prio  = 0;
      m_cnt   = 0;
      m_dup   = 1'b0;
      foreach (m_written[i]) m_written[i] = 1'b0;
      expq.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_phase = P_COL;
          m_cnt   = 0;
          m_dup   = 1'b0;
          foreach (m_written[i]) m_written[i] = 1'b0;
        end
        P_COL: if (g != '0) begin
          int    l;
          item_t it;
          l = 0;
          for (int k = 0; k < L; k++) if (g[k]) l = k;
          it = lq[l][0];
          m_gnt  = g;
          xfers++;
          glog.push_back(l);
          m_prio = (l + 1) % L;
          if (it.r < A && it.c < B &&
              !m_written[it.r * B + it.c]) begin
            m_written[it.r * B + it.c] = 1'b1;
            m_cnt++;
            expq.push_back(it);
            m_ov = 1'b1;
            if (m_cnt == CELLS) m_phase = P_WAIT;
          end else begin
            m_dup = 1'b1;
          end
        end
        P_WAIT: if (compile_done) m_phase = P_DONE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // monitor: compares DUT outputs mid-cycle
  always @(negedge clk) begin
    chk("lane_ready", 32'(bus.lane_ready), 32'(exp_grant()));
    chk("busy", 32'(busy),
        32'(m_phase == P_COL || m_phase == P_WAIT));
    chk("frame_done", 32'(frame_done), 32'(m_phase == P_DONE));
    chk("dup_error", 32'(dup_error), 32'(m_dup));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (bus.out_valid === 1'b1 && m_ov) begin
      if (expq.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        item_t it;
        it = expq.pop_front();
        chk("out_row", 32'(bus.out_row), 32'(it.r));
        chk("out_col", 32'(bus.out_col), 32'(it.c));
        chk("out_element", 32'(bus.out_element), 32'(it.d));
        outs++;
      end
    end
  end

  task automatic drive();
    logic [L-1:0]    v;
    logic [L*RW-1:0] rr;
    logic [L*CW-1:0] cc;
    logic [L*E-1:0]  dd;
    v = '0; rr = '0; cc = '0; dd = '0;
    for (int l = 0; l < L; l++) begin
      if (lq[l].size() > 0 && en_mask[l]) begin
        v[l] = 1'b1;
        rr[l*RW +: RW] = RW'(lq[l][0].r);
        cc[l*CW +: CW] = CW'(lq[l][0].c);
        dd[l*E +: E]   = lq[l][0].d;
      end
    end
    bus.lane_valid = v;
    bus.lane_row   = rr;
    bus.lane_col   = cc;
    bus.lane_data  = dd;
  endtask

  task automatic clear_lanes();
    for (int l = 0; l < L; l++) lq[l].delete();
    drive();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int l = 0; l < L; l++)
      if (m_gnt[l] && lq[l].size() > 0) void'(lq[l].pop_front());
    start = 1'b0;
    compile_done = 1'b0;
    if (rand_mode) begin
      en_mask = 4'($urandom_range(0, 15));
      if (m_phase == P_COL && $urandom_range(0, 9) == 0)
        start = 1'b1;
    end
    drive();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic run_until(input int target, input int budget);
    for (int i = 0; i < budget && m_phase != target; i++) tick();
    chk("reach_phase", 32'(m_phase), 32'(target));
  endtask

  task automatic run_until_cnt(input int n, input int budget);
    for (int i = 0; i < budget && m_cnt < n; i++) tick();
    chk("reach_count", 32'(m_cnt), 32'(n));
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
  endtask

  task automatic finish_frame();
    run_until(P_WAIT, 300);
    clear_lanes();
    repeat ($urandom_range(0, 3)) tick();
    compile_done = 1'b1;
    tick();
    settle();
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    tick();
    settle();
    chk("frame_done_low", 32'(frame_done), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int o0;
    int x0;
    en_mask = '1;
    drive();
    repeat (3) tick();
    settle();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_row", 32'(bus.out_row), 32'd0);
    chk("rst_out_col", 32'(bus.out_col), 32'd0);
    chk("rst_out_element", 32'(bus.out_element), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_dup_error", 32'(dup_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // idle lanes are never granted
    lq[1].push_back(mk(0, 0, 'hAA));
    drive();
    settle();
    chk("idle_ready", 32'(bus.lane_ready), 32'd0);
    clear_lanes();
    tick();

    // lanes 0 and 2 held valid: grants alternate 0,2,0,2
    lq[0].push_back(mk(0, 0, 'h51));
    lq[0].push_back(mk(1, 0, 'h53));
    lq[2].push_back(mk(0, 1, 'h52));
    lq[2].push_back(mk(1, 1, 'h54));
    drive();
    glog.delete();
    start_frame();
    run_until(P_WAIT, 30);
    chk("alt_grants", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk("alt_lane", 32'(glog[i]), (i % 2 == 1) ? 32'd2 : 32'd0);
    finish_frame();

    // plain 2x2 frame from one lane
    lq[1].push_back(mk(0, 0, 'h11));
    lq[1].push_back(mk(0, 1, 'h22));
    lq[1].push_back(mk(1, 0, 'h33));
    lq[1].push_back(mk(1, 1, 'h44));
    drive();
    o0 = outs;
    start_frame();
    run_until(P_WAIT, 30);
    settle();
    chk("frame_outs", 32'(outs - o0), 32'd4);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_no_ready", 32'(bus.lane_ready), 32'd0);
    finish_frame();

    // repeated (1,1) is accepted but dropped
    lq[3].push_back(mk(0, 0, 'h01));
    lq[3].push_back(mk(0, 1, 'h02));
    lq[3].push_back(mk(1, 1, 'h03));
    lq[3].push_back(mk(1, 1, 'h04));
    lq[3].push_back(mk(1, 0, 'h05));
    drive();
    start_frame();
    run_until_cnt(3, 30);
    settle();
    chk("dup_before", 32'(dup_error), 32'd0);
    x0 = xfers;
    tick();
    settle();
    chk("dup_xfer", 32'(xfers - x0), 32'd1);
    chk("dup_no_out", 32'(bus.out_valid), 32'd0);
    chk("dup_flag", 32'(dup_error), 32'd1);
    chk("dup_still_busy", 32'(busy), 32'd1);
    finish_frame();

    // all four lanes valid on the final element
    lq[0].push_back(mk(0, 0, 'h61));
    lq[0].push_back(mk(0, 1, 'h62));
    lq[0].push_back(mk(1, 0, 'h63));
    drive();
    start_frame();
    settle();
    chk("dup_cleared", 32'(dup_error), 32'd0);
    run_until_cnt(3, 30);
    for (int l = 0; l < L; l++) lq[l].push_back(mk(1, 1, 'hA0 + l));
    drive();
    x0 = xfers;
    tick();
    settle();
    chk("final_one_xfer", 32'(xfers - x0), 32'd1);
    chk("final_no_ready", 32'(bus.lane_ready), 32'd0);
    chk("final_out_valid", 32'(bus.out_valid), 32'd1);
    chk("final_lane1_data", 32'(bus.out_element), 32'hA1);
    finish_frame();

    // start during COLLECT is ignored
    lq[2].push_back(mk(0, 0, 'h71));
    lq[2].push_back(mk(0, 1, 'h72));
    drive();
    start_frame();
    run_until_cnt(2, 30);
    start = 1'b1;
    tick();
    settle();
    chk("restart_busy", 32'(busy), 32'd1);
    lq[2].push_back(mk(1, 0, 'h73));
    lq[2].push_back(mk(1, 1, 'h74));
    drive();
    run_until(P_WAIT, 10);
    finish_frame();

    // reset mid-frame abandons it
    for (int i = 0; i < 4; i++)
      lq[0].push_back(mk(i / 2, i % 2, 'h81 + i));
    drive();
    start_frame();
    run_until_cnt(2, 30);
    rst = 1'b1;
    tick();
    settle();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_row", 32'(bus.out_row), 32'd0);
    chk("mid_rst_col", 32'(bus.out_col), 32'd0);
    chk("mid_rst_element", 32'(bus.out_element), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.lane_ready), 32'd0);
    rst = 1'b0;
    clear_lanes();
    tick();
    for (int i = 0; i < 4; i++)
      lq[2].push_back(mk(i / 2, i % 2, $urandom_range(0, 255)));
    drive();
    o0 = outs;
    start_frame();
    run_until(P_WAIT, 30);
    settle();
    chk("clean_outs", 32'(outs - o0), 32'd4);
    finish_frame();

    // random frames with random addresses, repeats and gaps
    rand_mode = 1'b1;
    for (int f = 0; f < 8; f++) begin
      start_frame();
      for (int i = 0; i < 300 && m_phase == P_COL; i++) begin
        bit empty;
        empty = 1'b1;
        for (int l = 0; l < L; l++)
          if (lq[l].size() > 0) empty = 1'b0;
        if (empty) begin
          repeat ($urandom_range(1, 4))
            lq[$urandom_range(0, L-1)].push_back(
              mk($urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 255)));
          drive();
        end
        tick();
      end
      finish_frame();
    end
    rand_mode = 1'b0;
    en_mask = '1;
    repeat (3) tick();
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
